bram_tdp_be: RTL

Single-clock true-dual-port block RAM with per-byte write enables, selectable same-port write mode and an optional output register stage. Successor to the read-first TDP primitive. Address width derives from NUM_WORDS, and read-data outputs gain valid flags and an async-reset output path. Same-address write collisions are resolved deterministically and flagged. Used as backing store for register files, caches and scratchpads in the core and FPGA blocks.

---
 rtl/bram_pkg.sv | 44 ++++
 rtl/bram_rd_pipe.sv | 67 ++++++
 rtl/bram_tdp_be.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bram_pkg.sv
// -----------------------------------------------------------------------------
// bram_pkg
//   Shared types and helpers for the byte-enable true-dual-port block RAM.
//
//   write_mode_e : same-port read-during-write behaviour
//                  READ_FIRST  - a write returns the word as it was before the write
//                  WRITE_FIRST - a write returns the merged word (new lanes + old lanes)
//                  NO_CHANGE   - a write leaves the read data untouched, no valid pulse
//   byte_merge() : lane-wise merge of a new word into an old word under a
//                  byte write-enable mask.
// -----------------------------------------------------------------------------
package bram_pkg;

    typedef enum logic [1:0] {
        READ_FIRST  = 2'd0,
        WRITE_FIRST = 2'd1,
        NO_CHANGE   = 2'd2
    } write_mode_e;

    // Upper bounds for byte_merge operands. Callers zero-extend into these
    // widths and cast the result back down to their own word width.
    localparam int unsigned MAX_DATA_W = 1024;
    localparam int unsigned MAX_BYTES  = 128;

    // Lanes with we[b]=1 take new_word, all others keep old_word.
    // Bits at or above num_bytes*byte_width are passed through from old_word.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BYTES-1:0]  we,
        input int unsigned           num_bytes,
        input int unsigned           byte_width = 8
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
            if ((i < num_bytes * byte_width) && we[i / byte_width]) begin
                merged[i] = new_word[i];
            end
        end
        return merged;
    endfunction

endpackage : bram_pkg

// File: rtl/bram_rd_pipe.sv
// -----------------------------------------------------------------------------
// bram_rd_pipe
//   Read-data pipeline for one RAM port: a stage-1 capture register and an
//   optional stage-2 output register. Data holds its last value whenever no
//   new word is loaded; valid is a single-cycle pulse per loaded word.
//
//   Ports:
//     clk_i    in   1           clock
//     rst_i    in   1           asynchronous active-high reset
//     load_i   in   1           capture data_i into stage 1 on this edge
//     data_i   in   DATA_WIDTH  word to capture
//     data_o   out  DATA_WIDTH  read data from the last stage
//     valid_o  out  1           data_o was updated by this edge
// -----------------------------------------------------------------------------
module bram_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= load_i;
            if (load_i) begin
                s1_data <= data_i;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] s2_data;
        logic                  s2_valid;

        // Stage 2 is a plain copy every cycle; holding in stage 1 makes
        // stage 2 hold as well.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
            end else begin
                s2_data  <= s1_data;
                s2_valid <= s1_valid;
            end
        end

        assign data_o  = s2_data;
        assign valid_o = s2_valid;
    end else begin : g_no_out_reg
        assign data_o  = s1_data;
        assign valid_o = s1_valid;
    end

endmodule : bram_rd_pipe

// File: rtl/bram_tdp_be.sv
// -----------------------------------------------------------------------------
// bram_tdp_be
//   Single-clock true-dual-port RAM with per-byte write enables, selectable
//   same-port read-during-write mode and optional output register.
//   Read latency is 1 + OUT_REG cycles; validX_o marks each returned word.
//
//   Ports (port B mirrors port A):
//     clk_i        in   1           clock for both ports
//     rst_i        in   1           asynchronous active-high reset (outputs only)
//     enA_i        in   1           port A access enable
//     weA_i        in   NUM_BYTES   port A byte write enables (any set = write)
//     addrA_i      in   ADDR_WIDTH  port A word address
//     dataA_i      in   DATA_WIDTH  port A write data
//     dataA_o      out  DATA_WIDTH  port A read data (held while validA_o=0)
//     validA_o     out  1           dataA_o updated this cycle
//     collision_o  out  1           registered: both ports wrote the same word
//                                   with at least one common byte lane
//
//   Conflict rules: a same-cycle reader on the other port always sees the
//   old word; on a double write, lanes enabled on both ports take port A.
//   Addresses >= NUM_WORDS are ignored for writes and read back as zero.
// -----------------------------------------------------------------------------
module bram_tdp_be
    import bram_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  NUM_WORDS  = 32,
    parameter int unsigned  BYTE_WIDTH = 8,
    parameter write_mode_e  WRITE_MODE = READ_FIRST,
    parameter int unsigned  OUT_REG    = 0,
    localparam int unsigned ADDR_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int unsigned NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  enA_i,
    input  logic [NUM_BYTES-1:0]  weA_i,
    input  logic [ADDR_WIDTH-1:0] addrA_i,
    input  logic [DATA_WIDTH-1:0] dataA_i,
    output logic [DATA_WIDTH-1:0] dataA_o,
    output logic                  validA_o,

    input  logic                  enB_i,
    input  logic [NUM_BYTES-1:0]  weB_i,
    input  logic [ADDR_WIDTH-1:0] addrB_i,
    input  logic [DATA_WIDTH-1:0] dataB_i,
    output logic [DATA_WIDTH-1:0] dataB_o,
    output logic                  validB_o,

    output logic                  collision_o
);

    if ((DATA_WIDTH % BYTE_WIDTH) != 0 || DATA_WIDTH > MAX_DATA_W ||
        NUM_BYTES > MAX_BYTES) begin : g_bad_params
        $error("bram_tdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH and fit byte_merge");
    end

    // One bit wider than the address so a power-of-two depth is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(NUM_WORDS);

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

`ifndef SYNTHESIS
    initial begin
        for (int unsigned w = 0; w < NUM_WORDS; w++) begin
            mem[w] = '0;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Per-port views (index 0 = port A, 1 = port B)
    // -------------------------------------------------------------------------
    logic [1:0]                  en;
    logic [NUM_BYTES-1:0]        we      [2];
    logic [ADDR_WIDTH-1:0]       addr    [2];
    logic [DATA_WIDTH-1:0]       din     [2];
    logic [DATA_WIDTH-1:0]       rd_data [2];
    logic [1:0]                  rd_valid;
    logic [1:0]                  addr_ok;
    logic [1:0][NUM_BYTES-1:0]   wr_lane;

    assign en      = {enB_i, enA_i};
    assign we[0]   = weA_i;
    assign we[1]   = weB_i;
    assign addr[0] = addrA_i;
    assign addr[1] = addrB_i;
    assign din[0]  = dataA_i;
    assign din[1]  = dataB_i;

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  is_wr;
        logic [DATA_WIDTH-1:0] old_word;
        logic [DATA_WIDTH-1:0] merged_word;
        logic                  load;
        logic [DATA_WIDTH-1:0] load_data;

        assign addr_ok[p] = ({1'b0, addr[p]} < DEPTH);
        assign is_wr      = |we[p];
        assign wr_lane[p] = (en[p] && addr_ok[p]) ? we[p] : '0;

        // Pre-edge contents: this is what "old word" means for both this
        // port and a same-cycle reader on the other port.
        assign old_word    = addr_ok[p] ? mem[addr[p]] : '0;
        // Own-port merge only; the other port's lanes are never reflected.
        assign merged_word = DATA_WIDTH'(byte_merge(MAX_DATA_W'(old_word),
                                                    MAX_DATA_W'(din[p]),
                                                    MAX_BYTES'(we[p]),
                                                    NUM_BYTES, BYTE_WIDTH));

        // NOTE: every variable gets a default at the top of always_comb so
        // no path leaves it unassigned and no latch is inferred.
        always_comb begin
            load      = 1'b0;
            load_data = old_word;
            if (en[p]) begin
                if (!is_wr) begin
                    load = 1'b1;
                end else begin
                    case (WRITE_MODE)
                        READ_FIRST: begin
                            load = 1'b1;
                        end
                        WRITE_FIRST: begin
                            load      = 1'b1;
                            load_data = addr_ok[p] ? merged_word : '0;
                        end
                        default: begin
                            load = 1'b0;  // NO_CHANGE: hold data, no pulse
                        end
                    endcase
                end
            end
        end

        bram_rd_pipe #(
            .DATA_WIDTH (DATA_WIDTH),
            .OUT_REG    (OUT_REG)
        ) u_rd_pipe (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load_i  (load),
            .data_i  (load_data),
            .data_o  (rd_data[p]),
            .valid_o (rd_valid[p])
        );
    end

    assign dataA_o  = rd_data[0];
    assign validA_o = rd_valid[0];
    assign dataB_o  = rd_data[1];
    assign validB_o = rd_valid[1];

    // -------------------------------------------------------------------------
    // Memory write port logic. Port B lanes are applied first and port A
    // second, so on a shared lane the later non-blocking update (A) wins.
    // NOTE: the array has no reset branch; resetting it would prevent block
    // RAM inference and contents are defined by writes, not by reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (wr_lane[1][b]) begin
                mem[addr[1]][b*BYTE_WIDTH +: BYTE_WIDTH] <= din[1][b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (wr_lane[0][b]) begin
                mem[addr[0]][b*BYTE_WIDTH +: BYTE_WIDTH] <= din[0][b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Collision flag: one-cycle pulse after a double write sharing a lane.
    // -------------------------------------------------------------------------
    logic collision_next;

    assign collision_next = (addr[0] == addr[1]) && (|(wr_lane[0] & wr_lane[1]));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            collision_o <= 1'b0;
        end else begin
            collision_o <= collision_next;
        end
    end

endmodule : bram_tdp_be
